// File: rtl/window_ctrl_pkg.sv
// Shared types and width helpers for the sliding-window controller.
// Imported by the pixel counter and the window_ctrl top.
package window_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Counter width for a range of n values; never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pix_counter.sv
// Column/row raster counter holding the last accepted pixel position.
// Exposes the position the next increment would produce and a last-pixel flag.
module pix_counter
  import window_ctrl_pkg::*;
#(
  parameter  int W  = 640,
  parameter  int H  = 480,
  localparam int CW = cnt_w(W),
  localparam int RW = cnt_w(H)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] nxt_col_o,
  output logic [RW-1:0] nxt_row_o,
  output logic          last_o
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          col_wrap;
  logic          row_wrap;

  assign col_wrap = (col_q == CW'(W - 1));
  assign row_wrap = (row_q == RW'(H - 1));

  always_comb begin
    nxt_col_o = col_wrap ? '0 : col_q + 1'b1;
    nxt_row_o = row_q;
    if (col_wrap) begin
      nxt_row_o = row_wrap ? '0 : row_q + 1'b1;
    end
  end

  // Flags that the pixel about to be counted closes the frame.
  assign last_o = (nxt_col_o == CW'(W - 1)) &&
                  (nxt_row_o == RW'(H - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (inc_i) begin
      col_d = nxt_col_o;
      row_d = nxt_row_o;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;

endmodule

// File: rtl/window_ctrl.sv
// Frame sequencer for a KERNEL x KERNEL sliding window over a raster.
// Drives line-buffer shift enables and flags when the window is full.
module window_ctrl
  import window_ctrl_pkg::*;
#(
  parameter  int IMG_WIDTH  = 640,
  parameter  int IMG_HEIGHT = 480,
  parameter  int KERNEL     = 3,
  localparam int CW         = cnt_w(IMG_WIDTH),
  localparam int RW         = cnt_w(IMG_HEIGHT)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  input  logic          i_sof,
  input  logic          i_abort,
  output logic          o_shift,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_win_valid,
  output logic          o_eof,
  output logic          o_busy
);

  state_e        state_q, state_d;
  logic          win_q, win_d;
  logic          in_frame;
  logic          accept;
  logic          restart;
  logic          cnt_inc;
  logic          cnt_clr;
  logic          last;
  logic          to_run;
  logic [CW-1:0] nxt_col;
  logic [RW-1:0] nxt_row;
  logic [CW-1:0] pos_col;
  logic [RW-1:0] pos_row;

  assign in_frame = (state_q == FILL) || (state_q == RUN);

  // Abort wins over everything, including the shift enable.
  always_comb begin
    accept = 1'b0;
    if (!i_abort && i_valid) begin
      accept = (state_q == IDLE) ? i_sof : in_frame;
    end
  end

  assign restart = accept && i_sof;
  assign cnt_inc = accept && !i_sof;
  assign cnt_clr = i_abort || restart;

  pix_counter #(
    .W (IMG_WIDTH),
    .H (IMG_HEIGHT)
  ) u_cnt (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .inc_i     (cnt_inc),
    .clr_i     (cnt_clr),
    .col_o     (o_col),
    .row_o     (o_row),
    .nxt_col_o (nxt_col),
    .nxt_row_o (nxt_row),
    .last_o    (last)
  );

  // Position of the pixel being accepted this cycle.
  assign pos_col = restart ? '0 : nxt_col;
  assign pos_row = restart ? '0 : nxt_row;

  assign to_run = (pos_row == RW'(KERNEL - 1)) &&
                  (pos_col == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = FILL;
      end
      FILL: begin
        if (restart)              state_d = FILL;
        else if (accept && to_run) state_d = RUN;
      end
      RUN: begin
        if (restart)             state_d = FILL;
        else if (accept && last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (i_abort) state_d = IDLE;
  end

  always_comb begin
    win_d = 1'b0;
    if (accept &&
        (int'(pos_row) >= KERNEL - 1) &&
        (int'(pos_col) >= KERNEL - 1)) begin
      win_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
    end
  end

  assign o_shift     = accept;
  assign o_win_valid = win_q;
  assign o_eof       = (state_q == DONE);
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_window_ctrl.sv
// Directed bench for window_ctrl with an 8x6 image and 3x3 kernel.
// Short vector table plus frame-level sequences for the multi-cycle cases.
module tb_window_ctrl;

  localparam int W = 8;
  localparam int H = 6;
  localparam int K = 3;
  localparam int NPIX = W * H;

  logic       clk;
  logic       rst_n;
  logic       valid;
  logic       sof;
  logic       abort;
  logic       shift;
  logic [2:0] col;
  logic [2:0] row;
  logic       win;
  logic       eof;
  logic       busy;

  int checks;
  int errors;

  int s_shift;

  window_ctrl #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .KERNEL     (K)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (valid),
    .i_sof       (sof),
    .i_abort     (abort),
    .o_shift     (shift),
    .o_col       (col),
    .o_row       (row),
    .o_win_valid (win),
    .o_eof       (eof),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish, got running, need done");
    $fatal(1);
  end

  typedef struct {
    logic v;
    logic s;
    logic a;
    logic e_shift;
    int   e_col;
    int   e_row;
    logic e_win;
    logic e_eof;
    logic e_busy;
  } vec_t;

  vec_t vec [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive inputs after the edge, sample o_shift at the
  // falling edge, then leave time 1 after the next rising edge.
  task automatic step(input logic v, input logic s, input logic a);
    valid = v;
    sof   = s;
    abort = a;
    @(negedge clk);
    s_shift = int'(shift);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid = 1'b0;
    sof   = 1'b0;
    abort = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " col"},  int'(col),  0);
    chk({tag, " row"},  int'(row),  0);
    chk({tag, " win"},  int'(win),  0);
    chk({tag, " eof"},  int'(eof),  0);
    chk({tag, " busy"}, int'(busy), 0);
  endtask

  // Full frame, optionally with a bubble after every pixel.
  task automatic full_frame(input string tag, input bit bubbles);
    int shifts;
    int wins;
    int first_win;
    int early_eof;
    int bub_win;
    shifts    = 0;
    wins      = 0;
    first_win = -1;
    early_eof = 0;
    bub_win   = 0;
    for (int n = 0; n < NPIX; n++) begin
      step(1'b1, n == 0, 1'b0);
      shifts += s_shift;
      if (win) begin
        wins++;
        if (first_win < 0) first_win = n;
      end
      if (n < NPIX - 1 && eof) early_eof++;
      if (n < NPIX - 1 && bubbles) begin
        step(1'b0, 1'b0, 1'b0);
        shifts += s_shift;
        if (win) bub_win++;
        if (eof) early_eof++;
      end
    end
    chk({tag, " eof after last"},  int'(eof),  1);
    chk({tag, " busy in done"},    int'(busy), 1);
    chk({tag, " last col"},        int'(col),  W - 1);
    chk({tag, " last row"},        int'(row),  H - 1);
    step(1'b0, 1'b0, 1'b0);
    chk({tag, " eof one cycle"},   int'(eof),  0);
    chk({tag, " busy after done"}, int'(busy), 0);
    chk({tag, " shift count"},     shifts,     NPIX);
    chk({tag, " win count"},       wins,       (H - K + 1) * (W - K + 1));
    chk({tag, " first win pixel"}, first_win,  2 * W + 2);
    chk({tag, " early eof"},       early_eof,  0);
    chk({tag, " bubble win"},      bub_win,    0);
  endtask

  initial begin
    int eofs;
    int shifts;
    checks = 0;
    errors = 0;
    valid  = 1'b0;
    sof    = 1'b0;
    abort  = 1'b0;
    rst_n  = 1'b0;

    #12;
    chk("reset shift", int'(shift), 0);
    chk_idle("reset");
    do_reset();

    //           v  s  a  sh col row win eof busy
    vec[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    vec[1] = '{1, 1, 0, 1, 0, 0, 0, 0, 1};
    vec[2] = '{1, 0, 0, 1, 1, 0, 0, 0, 1};
    vec[3] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    vec[4] = '{1, 0, 1, 0, 0, 0, 0, 0, 0};
    vec[5] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    vec[6] = '{1, 1, 0, 1, 0, 0, 0, 0, 1};
    vec[7] = '{1, 1, 0, 1, 0, 0, 0, 0, 1};

    for (int i = 0; i < 8; i++) begin
      step(vec[i].v, vec[i].s, vec[i].a);
      chk($sformatf("vec%0d shift", i), s_shift,        int'(vec[i].e_shift));
      chk($sformatf("vec%0d col", i),   int'(col),      vec[i].e_col);
      chk($sformatf("vec%0d row", i),   int'(row),      vec[i].e_row);
      chk($sformatf("vec%0d win", i),   int'(win),      int'(vec[i].e_win));
      chk($sformatf("vec%0d eof", i),   int'(eof),      int'(vec[i].e_eof));
      chk($sformatf("vec%0d busy", i),  int'(busy),     int'(vec[i].e_busy));
    end

    do_reset();
    full_frame("cont", 1'b0);
    do_reset();
    full_frame("bubble", 1'b1);

    // Restart with a second sof at pixel 30.
    do_reset();
    for (int n = 0; n < 30; n++) step(1'b1, n == 0, 1'b0);
    chk("pre-restart win", int'(win), 1);
    step(1'b1, 1'b1, 1'b0);
    chk("restart shift", s_shift,    1);
    chk("restart col",   int'(col),  0);
    chk("restart row",   int'(row),  0);
    chk("restart win",   int'(win),  0);
    chk("restart busy",  int'(busy), 1);
    eofs   = 0;
    shifts = 1;
    for (int n = 1; n < NPIX; n++) begin
      if (eof) eofs++;
      step(1'b1, 1'b0, 1'b0);
      shifts += s_shift;
    end
    chk("restart early eof", eofs,      0);
    chk("restart shifts",    shifts,    NPIX);
    chk("restart eof",       int'(eof), 1);
    step(1'b0, 1'b0, 1'b0);
    chk("restart idle", int'(busy), 0);

    // Abort at pixel 20 with i_valid high.
    do_reset();
    for (int n = 0; n < 20; n++) step(1'b1, n == 0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("abort shift", s_shift, 0);
    chk_idle("abort");
    eofs   = 0;
    shifts = 0;
    for (int n = 0; n < 6; n++) begin
      step(1'b1, 1'b0, 1'b0);
      shifts += s_shift;
      if (eof || busy) eofs++;
    end
    chk("post-abort shifts", shifts,   0);
    chk("post-abort active", eofs,     0);
    chk("post-abort col",    int'(col), 0);

    // Asynchronous reset in the middle of RUN.
    do_reset();
    for (int n = 0; n < 20; n++) step(1'b1, n == 0, 1'b0);
    chk("pre-reset win", int'(win), 1);
    valid = 1'b1;
    sof   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async shift", int'(shift), 0);
    chk_idle("async");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0);
    chk("post-reset nosof shift", s_shift,    0);
    chk("post-reset nosof busy",  int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_ctrl.md
WINDOW_CTRL -- requirements
Module: window_ctrl

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per line; legal range is at least KERNEL.
REQ-002 Parameter IMG_HEIGHT, default 480, lines per frame; legal range is at least KERNEL.
REQ-003 Parameter KERNEL, default 3, window edge length in pixels; legal range 2..7.
REQ-004 Port i_clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 Port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port i_valid, input, 1 bit: an incoming pixel is present this cycle.
REQ-007 Port i_sof, input, 1 bit: start of frame; qualified by i_valid.
REQ-008 Port i_abort, input, 1 bit: synchronous frame abort.
REQ-009 Port o_shift, output, 1 bit: shift enable to every line-buffer and tap shift register.
REQ-010 Port o_col, output, $clog2(IMG_WIDTH) bits: column of the last accepted pixel.
REQ-011 Port o_row, output, $clog2(IMG_HEIGHT) bits: row of the last accepted pixel.
REQ-012 Port o_win_valid, output, 1 bit: the KERNEL x KERNEL window in the shift registers is fully populated.
REQ-013 Port o_eof, output, 1 bit: one-cycle pulse marking frame complete.
REQ-014 Port o_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The state machine SHALL have four states: IDLE, FILL, RUN, DONE.
REQ-016 IDLE SHALL go to FILL when i_valid && i_sof; that pixel is accepted as (row 0, col 0).
REQ-017 In IDLE, a pixel with i_valid && !i_sof SHALL be ignored: o_shift=0 and the counters hold.
REQ-018 A pixel is accepted in FILL or RUN on every cycle with i_valid=1.
REQ-019 o_shift SHALL be combinational, high exactly on cycles where a pixel is accepted.
REQ-020 On each accepted pixel, col SHALL increment; at col=IMG_WIDTH-1 it SHALL wrap to 0 and row SHALL increment.
REQ-021 FILL SHALL go to RUN on the acceptance of pixel (row KERNEL-1, col 0).
REQ-022 RUN SHALL go to DONE on the acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-023 DONE SHALL last exactly one cycle, assert o_eof=1, and return to IDLE.
REQ-024 In DONE, o_shift SHALL be 0 and any input pixel SHALL be dropped.
REQ-025 o_win_valid SHALL be registered: high in the cycle after an accepted pixel with row>=KERNEL-1 and col>=KERNEL-1, otherwise low; no skid.
REQ-026 An i_sof arriving in FILL or RUN SHALL restart the frame: that pixel becomes (0,0), the state becomes FILL, and o_win_valid=0 next cycle.
REQ-027 i_abort SHALL have priority over all inputs: next state IDLE, counters cleared, o_win_valid=0, no o_eof.
REQ-028 i_abort during a cycle with i_valid=1 SHALL still produce o_shift=0.
REQ-029 Gaps in i_valid (bubbles) SHALL hold all state and counters, and produce o_win_valid=0.

Reset
REQ-030 On i_rst_n low, the block SHALL asynchronously enter IDLE.
REQ-031 Reset values: o_col=0, o_row=0, o_win_valid=0, o_eof=0, o_busy=0; o_shift=0 follows from IDLE with no pixel.
REQ-032 Reset mid-frame SHALL discard the frame; the next frame requires i_sof.

Structure
REQ-033 Package window_ctrl_pkg SHALL hold the state enum (IDLE, FILL, RUN, DONE) and the width localparam helper functions.
REQ-034 Sub-module pix_counter SHALL implement the col/row wrap counter with inc, clr, and last-pixel flag; window_ctrl instantiates it once.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6, KERNEL=3)
REQ-035 Full frame, i_valid continuous, i_sof on the first pixel -> 48 o_shift pulses, 24 o_win_valid cycles, o_eof exactly 1 cycle after the 48th pixel, o_busy low after that.
REQ-036 First valid window: o_win_valid first high the cycle after pixel (2,2), i.e. the cycle after the 19th accepted pixel.
REQ-037 i_valid toggling 1/0 -> same totals as REQ-035; o_win_valid never high during a bubble.
REQ-038 Second i_sof at pixel 30 -> counters restart at (0,0), state FILL, and the next o_eof comes 48 accepted pixels after the restart.
REQ-039 i_abort at pixel 20 with i_valid=1 -> o_shift=0 that cycle, IDLE next, no o_eof; subsequent non-sof pixels are ignored.
REQ-040 i_rst_n asserted mid-RUN, asynchronously -> all outputs at their reset values before the next clock edge.
